jstk_spi_responder: RTL and testbench

- SPI mode-0 responder that emulates the 2-axis joystick peripheral on the PMOD SPI header.
- Lets the joystick SPI initiator and the servo path be exercised on hardware or in simulation without the physical joystick.
- Samples the x/y/button values presented at its inputs once per frame and shifts them out on MISO as the 5-byte joystick report.
- Captures the initiator's command byte.

---
 rtl/jstk_spi_responder_if.sv | 22 ++
 rtl/jstk_spi_responder.sv | 177 +++++++++++++++++
 tb/tb_jstk_spi_responder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jstk_spi_responder_if.sv
// SPI pin bundle between the joystick initiator and the responder.
// The initiator drives CS_n/SCK/MOSI; the responder drives MISO.
interface jstk_spi_responder_if;
    logic CS_n;
    logic SCK;
    logic MOSI;
    logic MISO;

    modport master (
        output CS_n,
        output SCK,
        output MOSI,
        input  MISO
    );

    modport slave (
        input  CS_n,
        input  SCK,
        input  MOSI,
        output MISO
    );
endinterface

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 responder that emulates the PMOD 2-axis joystick.
// Snapshots x_pos/y_pos/buttons at the CS_n fall and shifts the 5-byte
// report out on MISO, capturing the first received byte as cmd_byte.
// Optional build macro: JSTK_LED_CMD_EN enables the LED command decode
// (cmd_byte[7:2] == 6'b100000 sets led to cmd_byte[1:0] on a good frame).
//
// state | meaning
// IDLE  | waiting for CS_n falling edge; MISO=0, busy=0
// SHIFT | frame in progress; shifting on synchronized SCK edges
module jstk_spi_responder #(
    parameter int SYNC_STAGES = 2,   // at least 2
    parameter int FRAME_BYTES = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    jstk_spi_responder_if.slave  spi,
    input  logic [9:0]           x_pos,
    input  logic [9:0]           y_pos,
    input  logic [2:0]           buttons,
    output logic [7:0]           cmd_byte,
    output logic                 cmd_valid,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic [1:0]           led
);

    localparam int         FRAME_BITS   = FRAME_BYTES * 8;
    localparam logic [5:0] FRAME_BITS_C = 6'(FRAME_BITS);
    localparam logic [5:0] CNT_MAX      = 6'd63;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_d;
    logic                   sck_d;

    logic cs_s, sck_s, mosi_s;
    logic cs_fall, cs_rise, sck_rise, sck_fall;

    logic        load_frame;
    logic        rx_en;
    logic        tx_en;
    logic        end_frame;

    logic [39:0] tx_sr;
    logic [6:0]  rx_sr;
    logic [5:0]  bit_cnt;

    // Synchronizers and edge-history flops. Left unreset on purpose so a
    // CS_n already held low through reset does not look like a fresh edge.
    always_ff @(posedge CLK) begin
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.CS_n};
        sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi.SCK};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
        cs_d      <= cs_sync[SYNC_STAGES-1];
        sck_d     <= sck_sync[SYNC_STAGES-1];
    end

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign sck_rise = ~sck_d & sck_s;
    assign sck_fall = sck_d & ~sck_s;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes; a CS_n rise masks any SCK edge in the same cycle.
    always_comb begin
        state_nxt  = state;
        load_frame = 1'b0;
        rx_en      = 1'b0;
        tx_en      = 1'b0;
        end_frame  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    load_frame = 1'b1;
                    state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    end_frame = 1'b1;
                    state_nxt = IDLE;
                end else if (sck_rise) begin
                    rx_en = 1'b1;
                end else if (sck_fall) begin
                    tx_en = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shift registers, bit counter, command capture and frame status pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_sr      <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            cmd_byte   <= '0;
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (load_frame) begin
                tx_sr   <= {x_pos[7:0], 6'b0, x_pos[9:8],
                            y_pos[7:0], 6'b0, y_pos[9:8],
                            5'b0, buttons};
                bit_cnt <= '0;
            end
            if (rx_en) begin
                rx_sr <= {rx_sr[5:0], mosi_s};
                if (bit_cnt != CNT_MAX) begin
                    bit_cnt <= bit_cnt + 6'd1;
                end
                // Eighth bit arriving now: only the first byte is ever captured.
                if (bit_cnt == 6'd7) begin
                    cmd_byte  <= {rx_sr, mosi_s};
                    cmd_valid <= 1'b1;
                end
            end
            // Zeros shift in behind the report, so extra clocks read MISO=0.
            if (tx_en) begin
                tx_sr <= {tx_sr[38:0], 1'b0};
            end
            if (end_frame) begin
                if (bit_cnt == FRAME_BITS_C) begin
                    frame_done <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    assign spi.MISO = (state == SHIFT) ? tx_sr[39] : 1'b0;
    assign busy     = (state == SHIFT);

`ifdef JSTK_LED_CMD_EN
    logic [1:0] led_q;

    // LED command decode, applied only when a frame completes cleanly.
    always_ff @(posedge CLK) begin
        if (RST) begin
            led_q <= 2'b00;
        end else if (frame_done && (cmd_byte[7:2] == 6'b100000)) begin
            led_q <= cmd_byte[1:0];
        end
    end

    assign led = led_q;
`else
    assign led = 2'b00;
`endif

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: drives SPI frames at CLK/8 and
// checks the MISO report, command capture, status pulses and LED behaviour.
module tb_jstk_spi_responder;

    logic       CLK;
    logic       RST;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [2:0] buttons;
    logic [7:0] cmd_byte;
    logic       cmd_valid;
    logic       busy;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] led;

    jstk_spi_responder_if spi_if ();

    jstk_spi_responder #(
        .SYNC_STAGES (2),
        .FRAME_BYTES (5)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .spi        (spi_if.slave),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .buttons    (buttons),
        .cmd_byte   (cmd_byte),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .led        (led)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    int cv_cnt   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    int cv_bits  = -1;
    int bits_sent = 0;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (cmd_valid) begin
            cv_cnt  <= cv_cnt + 1;
            cv_bits <= bits_sent;
        end
        if (frame_done) done_cnt <= done_cnt + 1;
        if (frame_err)  err_cnt  <= err_cnt + 1;
        if (frame_done && frame_err) both_cnt <= both_cnt + 1;
    end

    function automatic logic [39:0] rpt(input logic [9:0] x, input logic [9:0] y,
                                        input logic [2:0] b);
        return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, b};
    endfunction

    // One SPI frame of nbits; MISO sampled just before each SCK rise.
    task automatic xfer(input int nbits, input logic [63:0] mosi_v,
                        input int rst_at, input int chg_at,
                        output logic [63:0] miso_v, output logic busy_mid);
        miso_v    = '0;
        bits_sent = 0;
        @(negedge CLK);
        spi_if.MOSI = mosi_v[63];
        spi_if.CS_n = 1'b0;
        repeat (6) @(negedge CLK);
        busy_mid = busy;
        for (int i = 0; i < nbits; i++) begin
            spi_if.MOSI = mosi_v[63-i];
            if (i == rst_at) begin
                RST = 1'b1;
                repeat (2) @(negedge CLK);
                RST = 1'b0;
            end
            if (i == chg_at) x_pos = 10'h3FF;
            repeat (4) @(negedge CLK);
            miso_v = {miso_v[62:0], spi_if.MISO};
            spi_if.SCK = 1'b1;
            bits_sent = i + 1;
            repeat (4) @(negedge CLK);
            spi_if.SCK = 1'b0;
        end
        repeat (4) @(negedge CLK);
        spi_if.CS_n = 1'b1;
        repeat (8) @(negedge CLK);
    endtask

    task automatic test_reset();
        int cv0, d0, e0;
        RST = 1'b1;
        spi_if.CS_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            spi_if.SCK = ~spi_if.SCK;
        end
        RST = 1'b0;
        cv0 = cv_cnt; d0 = done_cnt; e0 = err_cnt;
        checks++;
        if (spi_if.MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", spi_if.MISO); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++;
        if (cmd_byte !== 8'h00) begin errors++; $display("FAIL reset_cmd got %h exp 00", cmd_byte); end
        checks++;
        if (led !== 2'b00) begin errors++; $display("FAIL reset_led got %b exp 00", led); end
        for (int i = 0; i < 20; i++) begin
            repeat (4) @(negedge CLK);
            spi_if.SCK = ~spi_if.SCK;
        end
        spi_if.SCK = 1'b0;
        repeat (6) @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || spi_if.MISO !== 1'b0) begin
            errors++; $display("FAIL idle_sck busy %b miso %b exp 0 0", busy, spi_if.MISO);
        end
        checks++;
        if (cv_cnt - cv0 !== 0) begin errors++; $display("FAIL idle_cmd_valid got %0d exp 0", cv_cnt - cv0); end
        checks++;
        if ((done_cnt - d0) + (err_cnt - e0) !== 0) begin
            errors++; $display("FAIL idle_pulses got %0d exp 0", (done_cnt - d0) + (err_cnt - e0));
        end
    endtask

    task automatic test_normal();
        logic [63:0] mi;
        logic        bm;
        int cv0, d0, e0;
        x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
        cv0 = cv_cnt; d0 = done_cnt; e0 = err_cnt;
        xfer(40, {8'h81, 56'h0}, -1, -1, mi, bm);
        checks++;
        if (mi[39:0] !== 40'hA5_02_3C_01_05) begin errors++; $display("FAIL normal_miso got %h exp a5023c0105", mi[39:0]); end
        checks++;
        if (bm !== 1'b1) begin errors++; $display("FAIL normal_busy_mid got %b exp 1", bm); end
        checks++;
        if (cmd_byte !== 8'h81) begin errors++; $display("FAIL normal_cmd got %h exp 81", cmd_byte); end
        checks++;
        if (cv_cnt - cv0 !== 1) begin errors++; $display("FAIL normal_cv_count got %0d exp 1", cv_cnt - cv0); end
        checks++;
        if (cv_bits !== 8) begin errors++; $display("FAIL normal_cv_after_bit got %0d exp 8", cv_bits); end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL normal_done got %0d exp 1", done_cnt - d0); end
        checks++;
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL normal_err got %0d exp 0", err_cnt - e0); end
        checks++;
        if (busy !== 1'b0 || spi_if.MISO !== 1'b0) begin
            errors++; $display("FAIL normal_end_idle busy %b miso %b exp 0 0", busy, spi_if.MISO);
        end
    endtask

    task automatic test_snapshot();
        logic [63:0] mi;
        logic        bm;
        x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
        xfer(40, 64'h0, -1, 1, mi, bm);
        checks++;
        if (mi[39:0] !== rpt(10'h2A5, 10'h13C, 3'b101)) begin
            errors++; $display("FAIL snap_frame1 got %h exp %h", mi[39:0], rpt(10'h2A5, 10'h13C, 3'b101));
        end
        xfer(40, 64'h0, -1, -1, mi, bm);
        checks++;
        if (mi[39:0] !== 40'hFF_03_3C_01_05) begin errors++; $display("FAIL snap_frame2 got %h exp ff033c0105", mi[39:0]); end
    endtask

    task automatic test_short();
        logic [63:0] mi;
        logic        bm;
        int cv0, d0, e0;
        cv0 = cv_cnt; d0 = done_cnt; e0 = err_cnt;
        xfer(20, {8'h42, 56'h0}, -1, -1, mi, bm);
        checks++;
        if (err_cnt - e0 !== 1) begin errors++; $display("FAIL short_err got %0d exp 1", err_cnt - e0); end
        checks++;
        if (done_cnt - d0 !== 0) begin errors++; $display("FAIL short_done got %0d exp 0", done_cnt - d0); end
        checks++;
        if (cmd_byte !== 8'h42 || cv_cnt - cv0 !== 1) begin
            errors++; $display("FAIL short_cmd got %h/%0d exp 42/1", cmd_byte, cv_cnt - cv0);
        end
        cv0 = cv_cnt; d0 = done_cnt; e0 = err_cnt;
        xfer(5, {8'h55, 56'h0}, -1, -1, mi, bm);
        checks++;
        if (cmd_byte !== 8'h42 || cv_cnt - cv0 !== 0) begin
            errors++; $display("FAIL tiny_cmd got %h/%0d exp 42/0", cmd_byte, cv_cnt - cv0);
        end
        checks++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
            errors++; $display("FAIL tiny_pulses err %0d done %0d exp 1 0", err_cnt - e0, done_cnt - d0);
        end
        d0 = done_cnt; e0 = err_cnt;
        xfer(40, {8'h10, 56'h0}, -1, -1, mi, bm);
        checks++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            errors++; $display("FAIL after_short_full done %0d err %0d exp 1 0", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (cmd_byte !== 8'h10) begin errors++; $display("FAIL after_short_cmd got %h exp 10", cmd_byte); end
    endtask

    task automatic test_long();
        logic [63:0] mi;
        logic        bm;
        int d0, e0;
        x_pos = 10'h155; y_pos = 10'h2AA; buttons = 3'b010;
        d0 = done_cnt; e0 = err_cnt;
        xfer(44, 64'h0, -1, -1, mi, bm);
        checks++;
        if (mi[43:4] !== 40'h55_01_AA_02_02) begin errors++; $display("FAIL long_report got %h exp 5501aa0202", mi[43:4]); end
        checks++;
        if (mi[3:0] !== 4'b0000) begin errors++; $display("FAIL long_extra_bits got %b exp 0000", mi[3:0]); end
        checks++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
            errors++; $display("FAIL long_pulses err %0d done %0d exp 1 0", err_cnt - e0, done_cnt - d0);
        end
    endtask

    task automatic test_led();
        logic [63:0] mi;
        logic        bm;
        logic [1:0]  exp1, exp2, exp3;
`ifdef JSTK_LED_CMD_EN
        exp1 = 2'b11; exp2 = 2'b11; exp3 = 2'b01;
`else
        exp1 = 2'b00; exp2 = 2'b00; exp3 = 2'b00;
`endif
        xfer(40, {8'h83, 56'h0}, -1, -1, mi, bm);
        checks++;
        if (led !== exp1) begin errors++; $display("FAIL led_full_83 got %b exp %b", led, exp1); end
        xfer(30, {8'h81, 56'h0}, -1, -1, mi, bm);
        checks++;
        if (led !== exp2) begin errors++; $display("FAIL led_err_frame got %b exp %b", led, exp2); end
        xfer(40, {8'h81, 56'h0}, -1, -1, mi, bm);
        checks++;
        if (led !== exp3) begin errors++; $display("FAIL led_full_81 got %b exp %b", led, exp3); end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] mi;
        logic        bm;
        int cv0, d0, e0;
        x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
        cv0 = cv_cnt; d0 = done_cnt; e0 = err_cnt;
        xfer(40, {8'hC3, 56'h0}, 4, -1, mi, bm);
        checks++;
        if (cv_cnt - cv0 !== 0 || done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            errors++; $display("FAIL midrst_pulses cv %0d done %0d err %0d exp 0 0 0",
                               cv_cnt - cv0, done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (cmd_byte !== 8'h00 || led !== 2'b00) begin
            errors++; $display("FAIL midrst_regs cmd %h led %b exp 00 00", cmd_byte, led);
        end
        checks++;
        if (mi[35:0] !== 36'h0) begin errors++; $display("FAIL midrst_miso_idle got %h exp 0", mi[35:0]); end
        d0 = done_cnt;
        xfer(40, {8'h24, 56'h0}, -1, -1, mi, bm);
        checks++;
        if (mi[39:0] !== 40'hA5_02_3C_01_05 || done_cnt - d0 !== 1) begin
            errors++; $display("FAIL midrst_recover miso %h done %0d exp a5023c0105 1", mi[39:0], done_cnt - d0);
        end
        checks++;
        if (both_cnt !== 0) begin errors++; $display("FAIL done_err_overlap got %0d exp 0", both_cnt); end
    endtask

    initial begin
        RST         = 1'b1;
        spi_if.CS_n = 1'b1;
        spi_if.SCK  = 1'b0;
        spi_if.MOSI = 1'b0;
        x_pos       = '0;
        y_pos       = '0;
        buttons     = '0;
        repeat (2) @(negedge CLK);
        test_reset();
        test_normal();
        test_snapshot();
        test_short();
        test_long();
        test_led();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
